// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_multi
// Brief    : Runtime-programmable multi-channel clock divider. Each channel
//            produces a registered divided clock and a one-cycle tick at the
//            start of every divided period. Divisor updates are staged and
//            applied only at the channel's next period boundary.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_multi #(
    parameter int NUM_CH  = 2,
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 2,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [DIV_W-1:0]  div_data,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_pend
);

    localparam logic [DIV_W-1:0] C_DEF_DIV = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] C_MIN_DIV = DIV_W'(2);

    // Divisors below 2 cannot form a high and a low phase, so they are raised to 2.
    logic [DIV_W-1:0] w_clamp;
    assign w_clamp = (div_data < C_MIN_DIV) ? C_MIN_DIV : div_data;

    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_ch
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] act_q, act_d;
        logic [DIV_W-1:0] pend_q, pend_d;
        logic             pv_q, pv_d;
        logic             run_q, run_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             w_hit;
        logic             w_last;
        logic             w_start;
        logic [DIV_W:0]   w_cnt_inc;
        logic [DIV_W:0]   w_half_act;

        // Out-of-range selects match no channel, so those writes are dropped.
        assign w_hit = div_wr && (div_sel == SEL_W'(g));

        // Next-state: period start, period completion, counting and divisor staging.
        always_comb begin
            w_last     = run_q && (cnt_q == (act_q - DIV_W'(1)));
            w_start    = en[g] && (!run_q || w_last);
            w_cnt_inc  = {1'b0, cnt_q} + (DIV_W+1)'(1);
            w_half_act = ({1'b0, act_q} + (DIV_W+1)'(1)) >> 1;

            cnt_d  = cnt_q;
            run_d  = run_q;
            act_d  = act_q;
            pend_d = pend_q;
            pv_d   = pv_q;
            clk_d  = 1'b0;
            tick_d = 1'b0;

            if (w_start) begin
                // Counter restarts at 0, which is always inside the high phase
                // (half >= 1 for any divisor >= 2), whichever divisor is applied.
                cnt_d  = '0;
                run_d  = 1'b1;
                clk_d  = 1'b1;
                tick_d = 1'b1;
                if (pv_q) begin
                    act_d = pend_q;
                    pv_d  = 1'b0;
                end
            end else if (w_last) begin
                // Enable was dropped: the period has completed, go idle.
                cnt_d = '0;
                run_d = 1'b0;
            end else if (run_q) begin
                cnt_d = cnt_q + DIV_W'(1);
                clk_d = (w_cnt_inc < w_half_act);
            end else begin
                cnt_d = '0;
            end

            // A write in the same cycle as an apply stays pending for the next boundary.
            if (w_hit) begin
                pend_d = w_clamp;
                pv_d   = 1'b1;
            end
        end

        // Channel state and registered outputs, cleared asynchronously.
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                run_q  <= 1'b0;
                act_q  <= C_DEF_DIV;
                pend_q <= C_DEF_DIV;
                pv_q   <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                run_q  <= run_d;
                act_q  <= act_d;
                pend_q <= pend_d;
                pv_q   <= pv_d;
                clk_q  <= clk_d;
                tick_q <= tick_d;
            end
        end

        assign clk_out[g]  = clk_q;
        assign tick[g]     = tick_q;
        assign div_pend[g] = pv_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_multi
// Brief    : Self-checking bench for clk_div_multi. A period-position model
//            predicts every output each cycle; directed vectors add literal
//            expectations for the key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_multi;

    localparam int NCH = 3;
    localparam int DW  = 8;
    localparam int DEF = 2;
    localparam int SW  = 2;

    logic           clk_in = 1'b0;
    logic           rst_n  = 1'b0;
    logic [NCH-1:0] en     = '0;
    logic           div_wr = 1'b0;
    logic [SW-1:0]  div_sel = '0;
    logic [DW-1:0]  div_data = '0;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] div_pend;

    int n_tests = 0;
    int n_fail  = 0;

    clk_div_multi #(.NUM_CH(NCH), .DIV_W(DW), .DEF_DIV(DEF)) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .div_wr   (div_wr),
        .div_sel  (div_sel),
        .div_data (div_data),
        .clk_out  (clk_out),
        .tick     (tick),
        .div_pend (div_pend)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: each channel is described by its position inside the current
    // period (-1 = idle) and the divisor governing that period.
    int m_pos  [NCH];
    int m_div  [NCH];
    int m_pend [NCH];
    bit m_pv   [NCH];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_pos[c]  = -1;
            m_div[c]  = DEF;
            m_pend[c] = DEF;
            m_pv[c]   = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_in or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                for (int c = 0; c < NCH; c++) begin
                    bit st;
                    st = 1'b0;
                    if (m_pos[c] < 0) begin
                        st = en[c];
                    end else if (m_pos[c] == m_div[c] - 1) begin
                        if (en[c]) st = 1'b1;
                        else       m_pos[c] = -1;
                    end else begin
                        m_pos[c] = m_pos[c] + 1;
                    end
                    if (st) begin
                        m_pos[c] = 0;
                        if (m_pv[c]) begin
                            m_div[c] = m_pend[c];
                            m_pv[c]  = 1'b0;
                        end
                    end
                    if (div_wr && (int'(div_sel) == c)) begin
                        m_pend[c] = (int'(div_data) < 2) ? 2 : int'(div_data);
                        m_pv[c]   = 1'b1;
                    end
                end
            end
        end
    end

    // Compare every output against the model on each falling edge.
    initial begin
        forever begin
            logic [NCH-1:0] e_clk, e_tick, e_pend;
            @(negedge clk_in);
            for (int c = 0; c < NCH; c++) begin
                e_clk[c]  = (m_pos[c] >= 0) && (m_pos[c] < (m_div[c] + 1) / 2);
                e_tick[c] = (m_pos[c] == 0);
                e_pend[c] = m_pv[c];
            end
            chk("model_clk_out", 32'(clk_out), 32'(e_clk));
            chk("model_tick", 32'(tick), 32'(e_tick));
            chk("model_div_pend", 32'(div_pend), 32'(e_pend));
        end
    end

    task automatic step();
        @(negedge clk_in);
    endtask

    // Called on a falling edge; holds the strobe across exactly one rising edge.
    task automatic wr(input int sel, input int data);
        div_wr   = 1'b1;
        div_sel  = SW'(sel);
        div_data = DW'(data);
        @(negedge clk_in);
        div_wr   = 1'b0;
    endtask

    // Advance until ch shows a tick with no divisor pending; bounded.
    task automatic wait_tick(input int ch, input string nm);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (tick[ch] && !div_pend[ch]) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk(nm, 32'(found), 32'd1);
    endtask

    initial begin
        logic [5:0] exp_clk5, exp_tick5;
        logic [7:0] exp_clk6;
        int n, highs;

        // Reset state
        step(); step();
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_div_pend", 32'(div_pend), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_clk_out", 32'(clk_out), 32'd0);

        // 1: default divisor 2 on ch0/ch1, first edge one cycle after enable
        en = 3'b011;
        step();
        chk("t1_clk_hi", 32'(clk_out), 32'b011);
        chk("t1_tick_hi", 32'(tick), 32'b011);
        step();
        chk("t1_clk_lo", 32'(clk_out), 32'b000);
        chk("t1_tick_lo", 32'(tick), 32'b000);
        step();
        chk("t1_clk_hi2", 32'(clk_out), 32'b011);

        // 2: ch1 divisor 5 written during the high phase
        wr(1, 5);
        chk("t2_pend_set", 32'(div_pend[1]), 32'd1);
        chk("t2_low_finish", 32'(clk_out[1]), 32'd0);
        exp_clk5  = 6'b100111;   // LSB first: 1,1,1,0,0,1
        exp_tick5 = 6'b100001;   // LSB first: 1,0,0,0,0,1
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t2_clk_seq", 32'(clk_out[1]), 32'(exp_clk5[i]));
            chk("t2_tick_seq", 32'(tick[1]), 32'(exp_tick5[i]));
            if (i == 0) chk("t2_pend_clr", 32'(div_pend[1]), 32'd0);
        end

        // 3: divisors 0 and 1 clamp to 2
        wr(0, 0);
        wr(0, 1);
        for (int i = 0; i < 4; i++) step();
        chk("t3_pend_clr", 32'(div_pend[0]), 32'd0);

        // 4: ch0 divisor 6, enable dropped one cycle into the high phase
        wr(0, 6);
        wait_tick(0, "t4_tick_found");
        en[0] = 1'b0;
        exp_clk6 = 8'b00000011;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t4_clk_seq", 32'(clk_out[0]), 32'(exp_clk6[i]));
            chk("t4_no_tick", 32'(tick[0]), 32'd0);
        end

        // 5: back-to-back writes, only the last applies; out-of-range select ignored
        en[0] = 1'b1;
        step();
        chk("t5_restart_tick", 32'(tick[0]), 32'd1);
        wr(0, 8);
        wr(0, 3);
        wr(3, 9);
        chk("t5_pend_only_ch0", 32'(div_pend), 32'b001);
        wait_tick(0, "t5_tick_found");
        n = 0;
        highs = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            n++;
            if (tick[0]) break;
            highs += int'(clk_out[0]);
        end
        chk("t5_period", 32'(n), 32'd3);
        chk("t5_high_cycles", 32'(highs), 32'd2);
        chk("t5_no_pend", 32'(div_pend), 32'b000);

        // 6: asynchronous reset in the middle of a ch1 high phase
        wait_tick(1, "t6_tick_found");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_clk", 32'(clk_out), 32'd0);
        chk("t6_async_tick", 32'(tick), 32'd0);
        chk("t6_async_pend", 32'(div_pend), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("t6_post_clk1", 32'(clk_out[1]), 32'd1);
        chk("t6_post_tick1", 32'(tick[1]), 32'd1);
        step();
        chk("t6_post_clk0", 32'(clk_out[1]), 32'd0);
        step();
        chk("t6_post_tick2", 32'(tick[1]), 32'd1);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Runtime-programmable, multi-channel clock divider for the MCU core.
- Generates up to NUM_CH divided clocks from clk_in, plus a one-cycle tick per divided period. Ticks feed timer, UART baud and peripheral clock-enable logic.
- Each channel's divisor is written at runtime through a shared write port. A new divisor takes effect only at the channel's next period boundary. Enable/disable is glitch-free.

Parameters:
- NUM_CH, 2, number of independent divider channels (>=1)
- DIV_W, 8, width of divisor value
- DEF_DIV, 2, divisor loaded into every channel at reset (2..2^DIV_W-1)

Ports:
- clk_in  input  1  source clock; all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- en  input  NUM_CH  per-channel run enable
- div_wr  input  1  divisor write strobe, one clk_in cycle
- div_sel  input  max(1,clog2(NUM_CH))  channel addressed by write
- div_data  input  DIV_W  divisor value to write
- clk_out  output  NUM_CH  divided clocks, registered
- tick  output  NUM_CH  one-cycle pulse at start of each divided period, registered
- div_pend  output  NUM_CH  1 = written divisor not yet applied

Behaviour:
Reset (asynchronous, rst_n=0):
- Per channel: cnt=0, running=0, act_div=DEF_DIV, pend_div=DEF_DIV.
- Outputs: clk_out=0, tick=0, div_pend=0.

Per-channel state:
- cnt (DIV_W bits), act_div, pend_div, pend_valid, running.
- half = (act_div+1)>>1, i.e. high phase = ceil(div/2) cycles, low phase = floor(div/2) cycles.
- Examples: div=2 gives 1 high/1 low; div=5 gives 3 high/2 low.

Writes:
- When div_wr=1 and div_sel<NUM_CH: pend_div <= clamp(div_data), pend_valid <= 1.
- clamp maps 0 and 1 to 2; all other values pass unchanged.
- When div_sel>=NUM_CH the write is ignored.
- A second write before the first is applied overwrites it; only the last value is applied.
- div_pend = pend_valid.

Period start (cnt_next = 0) occurs on either:
- start: running=0 and en=1, or
- wrap: running=1, cnt=act_div-1 and en=1.

At period start:
- If pend_valid, act_div <= pend_div and pend_valid <= 0.
- A write and an apply in the same cycle: the new write wins. pend_valid stays 1 and the new value is applied at the next boundary.
- The half-threshold for the starting period uses the divisor applied at that boundary.

Running:
- When not wrapping, cnt <= cnt+1.
- clk_out <= (cnt_next < half). tick <= 1 only on period start.
- Latency: clk_out rises and tick pulses on the first posedge after en is sampled high, i.e. one cycle after en is asserted.

Disable:
- en=0 while running: the channel continues the current period to completion.
- When cnt reaches act_div-1 with en=0: running <= 0, cnt <= 0, clk_out held 0, no tick.
- If en returns to 1 before the period ends, running is uninterrupted; no restart or phase jump.

Idle:
- cnt=0, clk_out=0, tick=0. Writes are still accepted and applied at the next start.

General:
- Channels are fully independent; only the write port is shared.
- No combinational path from any input to any output.
- Reset mid-operation aborts immediately: outputs go 0 asynchronously and divisors return to DEF_DIV.

Test Plan:
1. Reset with NUM_CH=2, DIV_W=8, DEF_DIV=2, then en=2'b11 -> both clk_out toggle 1 high/1 low starting the cycle after en; tick every 2 cycles; div_pend=0.
2. ch1 running div=2; write div_sel=1, div_data=5 during the high phase -> div_pend[1]=1; current period completes (1 low); then 3 high/2 low; tick[1] every 5 cycles; div_pend[1] clears at that boundary.
3. Write div_data=0 then div_data=1 to ch0 -> each applied as 2; period stays 2 with no stall or glitch.
4. ch0 div=6, en[0] dropped 1 cycle into the high phase -> clk_out[0] finishes 3 high/3 low, then stays 0; no further tick; div_pend unaffected.
5. Back-to-back writes ch0 = 8 then 3 in consecutive cycles within one period -> only 3 is applied; div_sel=2 write of 9 -> no channel changes.
6. Async rst_n low mid high-phase with ch1 div=5 -> clk_out and tick go 0 immediately (before the next clk_in edge); after release with en=1, period is 2 (DEF_DIV).
